// File: rtl/hc4_pkg.sv
// Shared types and opcode field positions for the instruction decode pipe.
// Field positions are functions of the parameter values, so every user derives them the same way.
package hc4_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PREFIX = 2'd1,
    ST_FULL   = 2'd2
  } dec_state_e;

  // Opcode layout, LSB first: reg | ext | alu | ignored.
  function automatic int reg_lsb();
    return 0;
  endfunction

  function automatic int ext_pos(input int reg_sel_w);
    return reg_sel_w;
  endfunction

  function automatic int alu_lsb(input int reg_sel_w);
    return reg_sel_w + 1;
  endfunction

endpackage

// File: rtl/instdec_fields.sv
// Combinational opcode field extraction with active-low one-hot register select.
module instdec_fields
  import hc4_pkg::*;
#(
  parameter int  DATA_W    = 8,
  parameter int  REG_SEL_W = 2,
  parameter int  ALU_SEL_W = 3,
  localparam int NREG      = 2 ** REG_SEL_W
) (
  input  logic [DATA_W-1:0]    op,
  output logic                 ext,
  output logic [ALU_SEL_W-1:0] alu,
  output logic [NREG-1:0]      reg_sel_n
);

  localparam int REG_LSB = reg_lsb();
  localparam int EXT_POS = ext_pos(REG_SEL_W);
  localparam int ALU_LSB = alu_lsb(REG_SEL_W);
  localparam int FIELD_W = REG_SEL_W + 1 + ALU_SEL_W;

  logic [REG_SEL_W-1:0] reg_idx;

  assign reg_idx   = op[REG_LSB +: REG_SEL_W];
  assign ext       = op[EXT_POS];
  assign alu       = op[ALU_LSB +: ALU_SEL_W];
  assign reg_sel_n = ~(NREG'(1) << reg_idx);

  // Opcode bits above the defined fields are reserved and deliberately ignored.
  if (FIELD_W < DATA_W) begin : g_spare
    logic unused_spare_bits;
    assign unused_spare_bits = ^op[DATA_W-1:FIELD_W];
  end

endmodule

// File: rtl/instdec_pipe.sv
// One-stage instruction decoder: single-word instructions, or a prefix word plus an immediate word.
// The output register is held while downstream stalls; flush discards any prefix and any pending output.
module instdec_pipe
  import hc4_pkg::*;
#(
  parameter int  DATA_W    = 8,
  parameter int  REG_SEL_W = 2,
  parameter int  ALU_SEL_W = 3,
  localparam int NREG      = 2 ** REG_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*DATA_W-1:0]  rom_in,
  input  logic                 rom_valid,
  output logic                 rom_ready,
  input  logic                 flush,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic [NREG-1:0]      reg_sel_n,
  output logic [DATA_W-1:0]    data,
  output logic [DATA_W-1:0]    imm_hi,
  output logic                 imm_wide
);

  dec_state_e state, state_d;

  logic [DATA_W-1:0]    w_op, w_data;
  logic                 w_ext;
  logic [ALU_SEL_W-1:0] w_alu;
  logic [NREG-1:0]      w_sel_n;

  // The prefix is kept already decoded, so the immediate word needs no second decoder.
  logic [ALU_SEL_W-1:0] pfx_alu;
  logic [NREG-1:0]      pfx_sel_n;
  logic [DATA_W-1:0]    pfx_data;

  logic [NREG-1:0]      out_sel_n;
  logic                 accept, load_single, load_wide, store_prefix;

  assign w_op   = rom_in[2*DATA_W-1:DATA_W];
  assign w_data = rom_in[DATA_W-1:0];

  instdec_fields #(
    .DATA_W    (DATA_W),
    .REG_SEL_W (REG_SEL_W),
    .ALU_SEL_W (ALU_SEL_W)
  ) u_fields (
    .op        (w_op),
    .ext       (w_ext),
    .alu       (w_alu),
    .reg_sel_n (w_sel_n)
  );

  assign dec_valid = (state == ST_FULL);
  assign rom_ready = !flush && (state != ST_FULL || dec_ready);
  assign accept    = rom_valid && rom_ready;
  assign reg_sel_n = dec_valid ? out_sel_n : '1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state;
    load_single  = 1'b0;
    load_wide    = 1'b0;
    store_prefix = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY, ST_FULL: begin
          if (accept) begin
            if (w_ext) begin
              store_prefix = 1'b1;
              state_d      = ST_PREFIX;
            end else begin
              load_single = 1'b1;
              state_d     = ST_FULL;
            end
          end else if (state == ST_FULL && dec_ready) begin
            state_d = ST_EMPTY;
          end
        end
        // A second ext=1 word is still the immediate word; its opcode byte is ignored.
        ST_PREFIX: begin
          if (accept) begin
            load_wide = 1'b1;
            state_d   = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= ST_EMPTY;
      pfx_alu   <= '0;
      pfx_sel_n <= '1;
      pfx_data  <= '0;
      alu_sel   <= '0;
      out_sel_n <= '1;
      data      <= '0;
      imm_hi    <= '0;
      imm_wide  <= 1'b0;
    end else begin
      state <= state_d;

      if (flush) begin
        pfx_alu   <= '0;
        pfx_sel_n <= '1;
        pfx_data  <= '0;
      end else if (store_prefix) begin
        pfx_alu   <= w_alu;
        pfx_sel_n <= w_sel_n;
        pfx_data  <= w_data;
      end

      if (load_single) begin
        alu_sel   <= w_alu;
        out_sel_n <= w_sel_n;
        data      <= w_data;
        imm_hi    <= '0;
        imm_wide  <= 1'b0;
      end else if (load_wide) begin
        alu_sel   <= pfx_alu;
        out_sel_n <= pfx_sel_n;
        data      <= w_data;
        imm_hi    <= pfx_data;
        imm_wide  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instdec_pipe.sv
// Self-checking bench for instdec_pipe at default parameters: a transaction-level reference
// model compared every cycle, plus directed sequences with hand-computed literal expectations.
module tb_instdec_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rom_in;
  logic        rom_valid;
  logic        rom_ready;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  alu_sel;
  logic [3:0]  reg_sel_n;
  logic [7:0]  data;
  logic [7:0]  imm_hi;
  logic        imm_wide;

  int n_cmp  = 0;
  int n_fail = 0;

  instdec_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .rom_in    (rom_in),
    .rom_valid (rom_valid),
    .rom_ready (rom_ready),
    .flush     (flush),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .alu_sel   (alu_sel),
    .reg_sel_n (reg_sel_n),
    .data      (data),
    .imm_hi    (imm_hi),
    .imm_wide  (imm_wide)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction is "held" or not, a prefix is "pending" or not.
  logic       m_valid, m_pfx, m_wide;
  logic [7:0] m_pfx_op, m_pfx_d, m_data, m_hi;
  logic [2:0] m_alu;
  logic [1:0] m_reg;

  function automatic logic model_ready();
    return !flush && (!m_valid || dec_ready);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_pfx <= 1'b0; m_wide <= 1'b0;
      m_pfx_op <= 8'h00; m_pfx_d <= 8'h00; m_data <= 8'h00; m_hi <= 8'h00;
      m_alu <= 3'd0; m_reg <= 2'd0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_pfx   <= 1'b0;
    end else if (rom_valid && model_ready()) begin
      if (m_pfx) begin
        m_alu   <= 3'((m_pfx_op >> 3) & 8'h07);
        m_reg   <= 2'(m_pfx_op % 4);
        m_hi    <= m_pfx_d;
        m_data  <= rom_in % 256;
        m_wide  <= 1'b1;
        m_valid <= 1'b1;
        m_pfx   <= 1'b0;
      end else if (((rom_in >> 10) & 16'h1) != 0) begin
        m_pfx_op <= 8'(rom_in >> 8);
        m_pfx_d  <= rom_in % 256;
        m_pfx    <= 1'b1;
        m_valid  <= 1'b0;
      end else begin
        m_alu   <= 3'((rom_in >> 11) & 16'h7);
        m_reg   <= 2'((rom_in >> 8) % 4);
        m_hi    <= 8'h00;
        m_data  <= rom_in % 256;
        m_wide  <= 1'b0;
        m_valid <= 1'b1;
      end
    end else if (m_valid && dec_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cyc_rom_ready", rom_ready, model_ready());
    check("cyc_dec_valid", dec_valid, m_valid);
    check("cyc_reg_sel_n", reg_sel_n, m_valid ? (4'hF ^ (4'b1 << m_reg)) : 4'hF);
    check("cyc_alu_sel",   alu_sel,   m_alu);
    check("cyc_data",      data,      m_data);
    check("cyc_imm_hi",    imm_hi,    m_hi);
    check("cyc_imm_wide",  imm_wide,  m_wide);
  end

  // Apply one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [15:0] w, input logic rdy, input logic fl);
    rom_valid = v; rom_in = w; dec_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dec_valid"}, dec_valid, 1'b0);
    check({tag, "_reg_sel_n"}, reg_sel_n, 4'hF);
    check({tag, "_alu_sel"},   alu_sel,   3'd0);
    check({tag, "_data"},      data,      8'h00);
    check({tag, "_imm_hi"},    imm_hi,    8'h00);
    check({tag, "_imm_wide"},  imm_wide,  1'b0);
  endtask

  localparam logic [15:0] WORDS [7] = '{16'h1A55, 16'h0C12, 16'h0034, 16'h2B66,
                                        16'h0377, 16'h0C99, 16'h3F01};

  initial begin
    reset = 1'b1; rom_in = 16'h0; rom_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;
    cyc(0, 16'h0, 0, 0);
    cyc(1, 16'h1A55, 1, 0);
    check_reset_outputs("reset_hold");
    reset = 1'b0;

    // Single-word decode
    cyc(1, 16'h1A55, 1, 0);
    check("single_valid", dec_valid, 1'b1);
    check("single_alu",   alu_sel,   3'd3);
    check("single_sel",   reg_sel_n, 4'b1011);
    check("single_data",  data,      8'h55);
    check("single_wide",  imm_wide,  1'b0);
    cyc(0, 16'h0, 1, 0);
    check("drain_valid", dec_valid, 1'b0);
    check("drain_sel",   reg_sel_n, 4'hF);
    check("drain_alu_hold", alu_sel, 3'd3);

    // Prefix + immediate
    cyc(1, 16'h0C12, 1, 0);
    check("prefix_valid", dec_valid, 1'b0);
    cyc(1, 16'h0034, 1, 0);
    check("wide_valid", dec_valid, 1'b1);
    check("wide_alu",   alu_sel,   3'd1);
    check("wide_sel",   reg_sel_n, 4'b1110);
    check("wide_hi",    imm_hi,    8'h12);
    check("wide_data",  data,      8'h34);
    check("wide_flag",  imm_wide,  1'b1);

    // Stall three cycles with a word waiting
    for (int i = 0; i < 3; i++) begin
      rom_valid = 1'b1; rom_in = 16'h1A55; dec_ready = 1'b0; flush = 1'b0;
      #1;
      check("stall_ready", rom_ready, 1'b0);
      cyc(1, 16'h1A55, 0, 0);
      check("stall_data", data, 8'h34);
      check("stall_sel",  reg_sel_n, 4'b1110);
    end
    cyc(1, 16'h1A55, 1, 0);
    check("resume_alu",  alu_sel,  3'd3);
    check("resume_data", data,     8'h55);
    check("resume_hi",   imm_hi,   8'h00);

    // Back-to-back single words
    cyc(1, 16'h2B66, 1, 0);
    check("b2b2_sel", reg_sel_n, 4'b0111);
    check("b2b2_alu", alu_sel,   3'd5);
    cyc(1, 16'h0377, 1, 0);
    check("b2b3_valid", dec_valid, 1'b1);
    check("b2b3_sel",   reg_sel_n, 4'b0111);
    check("b2b3_alu",   alu_sel,   3'd0);

    // FULL accepting a prefix, then a second ext=1 word as the immediate
    cyc(1, 16'h0C12, 1, 0);
    check("full_to_pfx_valid", dec_valid, 1'b0);
    cyc(1, 16'h0C99, 1, 0);
    check("dbl_ext_hi",   imm_hi,    8'h12);
    check("dbl_ext_data", data,      8'h99);
    check("dbl_ext_sel",  reg_sel_n, 4'b1110);
    check("dbl_ext_wide", imm_wide,  1'b1);

    // Flush while FULL and stalled, then flush dropping a prefix
    cyc(1, 16'h1A55, 0, 1);
    check("flush_full_valid", dec_valid, 1'b0);
    cyc(1, 16'h0C12, 1, 0);
    cyc(1, 16'h0034, 1, 1);
    check("flush_valid", dec_valid, 1'b0);
    check("flush_sel",   reg_sel_n, 4'hF);
    cyc(1, 16'h1A55, 1, 0);
    check("post_flush_wide", imm_wide, 1'b0);
    check("post_flush_alu",  alu_sel,  3'd3);
    check("post_flush_data", data,     8'h55);

    // Asynchronous reset in PREFIX
    cyc(1, 16'h0C12, 1, 0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_pfx");
    cyc(0, 16'h0, 1, 0);
    reset = 1'b0;
    cyc(1, 16'h0034, 1, 0);
    check("after_rst_wide", imm_wide,  1'b0);
    check("after_rst_sel",  reg_sel_n, 4'b1110);
    check("after_rst_data", data,      8'h34);

    // Asynchronous reset in FULL while stalled
    cyc(1, 16'h2B66, 0, 0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_full");
    cyc(0, 16'h0, 1, 0);
    reset = 1'b0;

    // Mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 3) != 0, WORDS[$urandom_range(0, 6)],
          $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end
    cyc(0, 16'h0, 1, 0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
